// File: rtl/clock_mode_ctrl.sv
// Alarm-clock mode controller: 1 s tick divider, set-mode adjust pulses, alarm match and buzzer.
// Latency: button pulse -> mode/enable/up_down outputs one cycle later; blink/buzzer follow state combinationally.
// Backpressure: none; buttons are single-cycle pulses consumed in the cycle they arrive.
module clock_mode_ctrl #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int RING_SECS = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_c,
    input  logic        btn_u,
    input  logic        btn_d,
    input  logic        btn_l,
    input  logic        btn_r,
    input  logic        alarm_on,
    input  logic [12:0] time_hm,
    input  logic        time_sec_z,
    input  logic [12:0] alarm_hm,
    output logic        tick_en,
    output logic        tm_enh,
    output logic        tm_enm,
    output logic        al_enh,
    output logic        al_enm,
    output logic        up_down,
    output logic [1:0]  mode,
    output logic        field_sel,
    output logic        blink,
    output logic        buzzer
);

    localparam int               DIV_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(TICK_DIV / 2);
    localparam logic [7:0]       RING_LAST = 8'(RING_SECS);

    typedef enum logic [1:0] {
        CLOCK     = 2'd0,
        SET_TIME  = 2'd1,
        SET_ALARM = 2'd2,
        RINGING   = 2'd3
    } mode_t;

    mode_t            state_q;
    mode_t            state_d;
    logic [DIV_W-1:0] div_cnt;
    logic [7:0]       ring_cnt_q;
    logic [7:0]       ring_cnt_d;
    logic             field_sel_q;
    logic             field_sel_d;
    logic             match;
    logic             match_q;
    logic             trigger;
    logic             any_btn;
    logic             in_set;
    logic             adjust;

    assign match   = alarm_on && (time_hm == alarm_hm) && time_sec_z;
    assign trigger = match && !match_q;
    assign any_btn = btn_c | btn_u | btn_d | btn_l | btn_r;
    assign in_set  = (state_q == SET_TIME) || (state_q == SET_ALARM);
    // btn_c owns the cycle, and opposing up/down pulses cancel out.
    assign adjust  = in_set && !btn_c && (btn_u ^ btn_d);

    always_comb begin
        state_d     = state_q;
        ring_cnt_d  = ring_cnt_q;
        field_sel_d = field_sel_q;
        case (state_q)
            CLOCK: begin
                if (btn_c) begin
                    state_d     = SET_TIME;
                    field_sel_d = 1'b0;
                end else if (trigger) begin
                    state_d    = RINGING;
                    ring_cnt_d = '0;
                end
            end
            SET_TIME, SET_ALARM: begin
                if (btn_c) begin
                    state_d = (state_q == SET_TIME) ? SET_ALARM : CLOCK;
                end else if (btn_l) begin
                    field_sel_d = 1'b1;
                end else if (btn_r) begin
                    field_sel_d = 1'b0;
                end
            end
            RINGING: begin
                if (any_btn || (ring_cnt_q == RING_LAST)) begin
                    state_d = CLOCK;
                end else if (tick_en) begin
                    ring_cnt_d = ring_cnt_q + 8'd1;
                end
            end
            default: state_d = CLOCK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= CLOCK;
            div_cnt     <= '0;
            ring_cnt_q  <= '0;
            field_sel_q <= 1'b0;
            match_q     <= 1'b0;
            tick_en     <= 1'b0;
            tm_enh      <= 1'b0;
            tm_enm      <= 1'b0;
            al_enh      <= 1'b0;
            al_enm      <= 1'b0;
            up_down     <= 1'b1;
        end else begin
            state_q     <= state_d;
            div_cnt     <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            ring_cnt_q  <= ring_cnt_d;
            field_sel_q <= field_sel_d;
            match_q     <= match;
            // Time is frozen while it is being set.
            tick_en     <= (div_cnt == DIV_LAST) && (state_q != SET_TIME);
            tm_enh      <= adjust && (state_q == SET_TIME) && field_sel_q;
            tm_enm      <= adjust && (state_q == SET_TIME) && !field_sel_q;
            al_enh      <= adjust && (state_q == SET_ALARM) && field_sel_q;
            al_enm      <= adjust && (state_q == SET_ALARM) && !field_sel_q;
            up_down     <= !(adjust && btn_d);
        end
    end

    assign mode      = state_q;
    assign field_sel = field_sel_q;
    assign blink     = (div_cnt < DIV_HALF);
    assign buzzer    = (state_q == RINGING) && blink;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl with TICK_DIV=4, RING_SECS=3.
module tb_clock_mode_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_c, btn_u, btn_d, btn_l, btn_r;
    logic        alarm_on;
    logic [12:0] time_hm;
    logic        time_sec_z;
    logic [12:0] alarm_hm;
    logic        tick_en, tm_enh, tm_enm, al_enh, al_enm, up_down;
    logic [1:0]  mode;
    logic        field_sel, blink, buzzer;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic       tick_en;
        logic [3:0] en;        // {tm_enh, tm_enm, al_enh, al_enm}
        logic       up_down;
        logic [1:0] mode;
        logic       field_sel;
        logic       blink;
        logic       buzzer;
    } outs_t;

    typedef struct packed {
        logic [4:0] btn;       // {c, u, d, l, r}
        outs_t      exp;
    } vec_t;

    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] BC   = 5'b10000;
    localparam logic [4:0] BU   = 5'b01000;
    localparam logic [4:0] BD   = 5'b00100;
    localparam logic [4:0] BL   = 5'b00010;
    localparam logic [4:0] BR   = 5'b00001;

    outs_t      act_o;
    outs_t      rst_o;
    vec_t       vecs [29];
    logic [1:0] model_div;

    clock_mode_ctrl #(.TICK_DIV(4), .RING_SECS(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_c      (btn_c),
        .btn_u      (btn_u),
        .btn_d      (btn_d),
        .btn_l      (btn_l),
        .btn_r      (btn_r),
        .alarm_on   (alarm_on),
        .time_hm    (time_hm),
        .time_sec_z (time_sec_z),
        .alarm_hm   (alarm_hm),
        .tick_en    (tick_en),
        .tm_enh     (tm_enh),
        .tm_enm     (tm_enm),
        .al_enh     (al_enh),
        .al_enm     (al_enm),
        .up_down    (up_down),
        .mode       (mode),
        .field_sel  (field_sel),
        .blink      (blink),
        .buzzer     (buzzer)
    );

    always #5 clk = ~clk;

    assign act_o = {tick_en, tm_enh, tm_enm, al_enh, al_enm, up_down, mode, field_sel, blink, buzzer};

    // Reference phase of the 4-cycle divider, used for blink/buzzer expectations while ringing.
    always @(posedge clk) begin
        if (!rst) model_div <= 2'd0;
        else      model_div <= model_div + 2'd1;
    end

    function automatic vec_t v(input logic [4:0] b, input logic tk, input logic [3:0] en,
                               input logic ud, input logic [1:0] md, input logic fs, input logic bl);
        vec_t r;
        r.btn = b;
        r.exp = {tk, en, ud, md, fs, bl, 1'b0};
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks;
        int guard;

        // Idle CLOCK: ticks on 4, 8, 12 and blink 1,1,0,0
        vecs[0]  = v(NONE,    0, 4'b0000, 1, 2'd0, 0, 1);
        vecs[1]  = v(NONE,    0, 4'b0000, 1, 2'd0, 0, 0);
        vecs[2]  = v(NONE,    0, 4'b0000, 1, 2'd0, 0, 0);
        vecs[3]  = v(NONE,    1, 4'b0000, 1, 2'd0, 0, 1);
        vecs[4]  = v(NONE,    0, 4'b0000, 1, 2'd0, 0, 1);
        vecs[5]  = v(NONE,    0, 4'b0000, 1, 2'd0, 0, 0);
        vecs[6]  = v(NONE,    0, 4'b0000, 1, 2'd0, 0, 0);
        vecs[7]  = v(NONE,    1, 4'b0000, 1, 2'd0, 0, 1);
        vecs[8]  = v(NONE,    0, 4'b0000, 1, 2'd0, 0, 1);
        vecs[9]  = v(NONE,    0, 4'b0000, 1, 2'd0, 0, 0);
        vecs[10] = v(NONE,    0, 4'b0000, 1, 2'd0, 0, 0);
        vecs[11] = v(NONE,    1, 4'b0000, 1, 2'd0, 0, 1);
        // SET_TIME: hours up, tick suppressed at the wrap
        vecs[12] = v(BC,      0, 4'b0000, 1, 2'd1, 0, 1);
        vecs[13] = v(BL,      0, 4'b0000, 1, 2'd1, 1, 0);
        vecs[14] = v(BU,      0, 4'b1000, 1, 2'd1, 1, 0);
        vecs[15] = v(NONE,    0, 4'b0000, 1, 2'd1, 1, 1);
        vecs[16] = v(NONE,    0, 4'b0000, 1, 2'd1, 1, 1);
        vecs[17] = v(NONE,    0, 4'b0000, 1, 2'd1, 1, 0);
        vecs[18] = v(NONE,    0, 4'b0000, 1, 2'd1, 1, 0);
        vecs[19] = v(NONE,    0, 4'b0000, 1, 2'd1, 1, 1);
        // SET_ALARM: minutes down, time keeps ticking, u+d ignored, btn_c priority
        vecs[20] = v(BC,      0, 4'b0000, 1, 2'd2, 1, 1);
        vecs[21] = v(BR,      0, 4'b0000, 1, 2'd2, 0, 0);
        vecs[22] = v(BD,      0, 4'b0001, 0, 2'd2, 0, 0);
        vecs[23] = v(NONE,    1, 4'b0000, 1, 2'd2, 0, 1);
        vecs[24] = v(BU | BD, 0, 4'b0000, 1, 2'd2, 0, 1);
        vecs[25] = v(BL,      0, 4'b0000, 1, 2'd2, 1, 0);
        vecs[26] = v(BU,      0, 4'b0010, 1, 2'd2, 1, 0);
        vecs[27] = v(BC | BU, 1, 4'b0000, 1, 2'd0, 1, 1);
        vecs[28] = v(BD,      0, 4'b0000, 1, 2'd0, 1, 1);

        rst_o = {1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0};

        rst = 1'b0;
        {btn_c, btn_u, btn_d, btn_l, btn_r} = NONE;
        alarm_on   = 1'b0;
        time_hm    = 13'h0000;
        alarm_hm   = 13'h0111;
        time_sec_z = 1'b0;
        step();
        step();
        check("reset_state", 32'(act_o), 32'(rst_o));
        rst = 1'b1;

        for (int i = 0; i < 29; i++) begin
            {btn_c, btn_u, btn_d, btn_l, btn_r} = vecs[i].btn;
            step();
            {btn_c, btn_u, btn_d, btn_l, btn_r} = NONE;
            check($sformatf("vec%0d", i), 32'(act_o), 32'(vecs[i].exp));
        end

        // Alarm match edge rings; buzzer follows blink; button dismisses; held match does not re-fire
        alarm_on   = 1'b1;
        time_hm    = 13'h0730;
        alarm_hm   = 13'h0730;
        time_sec_z = 1'b0;
        step();
        check("no_match_mode", 32'(mode), 32'd0);
        time_sec_z = 1'b1;
        step();
        check("ring_enter", 32'(mode), 32'd3);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("ring_mode%0d", i), 32'(mode), 32'd3);
            check($sformatf("ring_blink%0d", i), 32'(blink), 32'(model_div < 2'd2));
            check($sformatf("ring_buzz%0d", i), 32'(buzzer), 32'(model_div < 2'd2));
            step();
        end
        btn_u = 1'b1;
        step();
        btn_u = 1'b0;
        check("dismiss_mode", 32'(mode), 32'd0);
        check("dismiss_buzz", 32'(buzzer), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("held_match%0d", i), 32'(mode), 32'd0);
        end

        // Auto-dismiss after RING_SECS ticks
        time_sec_z = 1'b0;
        step();
        time_sec_z = 1'b1;
        step();
        check("ring2_enter", 32'(mode), 32'd3);
        ticks = 0;
        guard = 0;
        while (mode == 2'd3 && guard < 40) begin
            if (tick_en) ticks++;
            step();
            guard++;
        end
        check("ring_timeout_mode", 32'(mode), 32'd0);
        check("ring_tick_count", 32'(ticks), 32'd3);
        check("ring_timeout_buzz", 32'(buzzer), 32'd0);

        // btn_c coincident with match edge: match lost, SET_TIME with field_sel cleared
        time_sec_z = 1'b0;
        step();
        time_sec_z = 1'b1;
        btn_c      = 1'b1;
        step();
        btn_c = 1'b0;
        check("btnc_match_mode", 32'(mode), 32'd1);
        check("btnc_match_fsel", 32'(field_sel), 32'd0);
        step();
        check("btnc_match_stay", 32'(mode), 32'd1);
        check("btnc_match_buzz", 32'(buzzer), 32'd0);
        btn_c = 1'b1;
        step();
        step();
        btn_c = 1'b0;
        check("back_to_clock", 32'(mode), 32'd0);

        // Reset while ringing
        time_sec_z = 1'b0;
        step();
        time_sec_z = 1'b1;
        step();
        check("ring3_enter", 32'(mode), 32'd3);
        rst      = 1'b0;
        alarm_on = 1'b0;
        step();
        check("reset_in_ring", 32'(act_o), 32'(rst_o));
        rst = 1'b1;
        step();
        step();
        check("post_reset_blink", 32'(blink), 32'd0);
        check("post_reset_mode", 32'(mode), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
